congestion_detector: RTL and testbench
======================================

CONGESTION_DETECTOR -- requirements
Module: congestion_detector

Interface
REQ-001 Parameter WIDTH, default 8: width of queue_count.
REQ-002 Parameter HIGH_MARK, default 10: queue level at or above which congestion is qualified.
REQ-003 Parameter LOW_MARK, default 4: queue level at or below which congestion is released; LOW_MARK < HIGH_MARK SHALL hold.
REQ-004 Parameter DWELL, default 3: consecutive qualifying cycles required to enter or leave congestion; DWELL >= 1.
REQ-005 clock  input  1  single clock, one period = one second; all flops on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 car_arrive  input  1  asynchronous level from the upstream main-road loop, high while a vehicle is over it.
REQ-008 car_depart  input  1  asynchronous level from the main-road stop-line loop, high while a vehicle is over it.
REQ-009 main_road  input  2  light code from the controller: 00 go, 01 go_attention, 10 stop, 11 stop_attention.
REQ-010 congestion  output  1  main road congested; drives the controller's congestion input.
REQ-011 queue_count  output  WIDTH  current vehicle estimate between the two loops.
REQ-012 violation  output  1  one-cycle pulse on a departure while main_road = 10.

Function
REQ-013 Each sensor SHALL pass through two synchronizer flops (s1, s2) and a history flop (p); event = s2 & ~p.
REQ-014 A sensor rising before edge N SHALL update queue_count at edge N+2, visible after it (3-edge latency).
REQ-015 Arrival event only: queue_count +1, saturating at 2^WIDTH-1.
REQ-016 Departure event only: queue_count -1, saturating at 0.
REQ-017 Arrival and departure events in the same cycle: queue_count unchanged, including at 0 and at max.
REQ-018 A sensor held high SHALL produce exactly one event until it returns low for at least one sampled cycle.
REQ-019 violation SHALL be high for exactly the cycle after a departure event whose cycle saw main_road = 10; no pulse for 00, 01, 11.
REQ-020 A violating departure SHALL still decrement queue_count per REQ-016/017.
REQ-021 FSM states: CLEAR, RISING, CONGESTED, FALLING; a dwell counter dcnt (ceil(log2(DWELL))+1 bits) is cleared on every state change.
REQ-022 CLEAR: queue_count >= HIGH_MARK -> RISING; else stay.
REQ-023 RISING: queue_count < HIGH_MARK -> CLEAR; else dcnt = DWELL-1 -> CONGESTED; else dcnt +1.
REQ-024 CONGESTED: queue_count <= LOW_MARK -> FALLING; else stay.
REQ-025 FALLING: queue_count > LOW_MARK -> CONGESTED; else dcnt = DWELL-1 -> CLEAR; else dcnt +1.
REQ-026 FSM SHALL evaluate the registered queue_count, i.e. the value present before the current edge's update.
REQ-027 congestion SHALL be 1 exactly when the state register is CONGESTED or FALLING; decoded from state only, glitch-free.
REQ-028 With DWELL=3, congestion SHALL rise 4 edges after the edge at which queue_count first reaches HIGH_MARK and stays there.
REQ-029 Levels between LOW_MARK and HIGH_MARK SHALL leave congestion unchanged (hysteresis).
REQ-030 main_road SHALL NOT affect queue_count or the FSM; it feeds only violation.

Reset
REQ-031 With reset high at a rising edge: queue_count = 0, state = CLEAR, dcnt = 0, congestion = 0, violation = 0, all synchronizer and history flops = 0.
REQ-032 reset SHALL override any same-cycle event; a sensor held high through reset SHALL count once after release.
REQ-033 Reset mid-CONGESTED SHALL drop congestion at that edge, with no FALLING dwell.

Verification
REQ-034 Apply 10 separate arrival pulses, each 2 cycles high and 2 low, no departures -> queue_count = 10; congestion rises 4 edges after the count reaches 10.
REQ-035 From queue 10 and congested, apply 6 departures -> congestion stays 1 while the count is 9..5, then falls DWELL+1 edges after the count reaches 4.
REQ-036 Hold car_arrive high for 50 cycles -> queue_count +1 only.
REQ-037 Drive simultaneous arrival and departure edges at queue 0 -> queue stays 0, no underflow; a lone departure at 0 -> queue stays 0.
REQ-038 Apply a departure with main_road = 10 -> violation is one 1-cycle pulse and queue decrements; the same departure with main_road = 00 -> no pulse.
REQ-039 Assert reset while CONGESTED with queue 12 and car_arrive high -> next cycle queue 0, congestion 0; after release, queue becomes 1 at edge +3.

Source files
------------

// File: rtl/congestion_detector_if.sv
// Sensor, light-code and status signals between the
// intersection controller and the congestion detector.
interface congestion_detector_if #(
    parameter int WIDTH = 8
);
    logic             car_arrive;
    logic             car_depart;
    logic [1:0]       main_road;
    logic             congestion;
    logic [WIDTH-1:0] queue_count;
    logic             violation;

    modport master (
        output car_arrive,
        output car_depart,
        output main_road,
        input  congestion,
        input  queue_count,
        input  violation
    );

    modport slave (
        input  car_arrive,
        input  car_depart,
        input  main_road,
        output congestion,
        output queue_count,
        output violation
    );
endinterface

// File: rtl/congestion_detector.sv
// Main-road queue estimator with hysteretic, dwell-qualified
// congestion flag and red-light departure violation pulse.
module congestion_detector #(
    parameter int WIDTH     = 8,
    parameter int HIGH_MARK = 10,
    parameter int LOW_MARK  = 4,
    parameter int DWELL     = 3
) (
    input logic           clock,
    input logic           reset,
    congestion_detector_if.slave bus
);
    localparam int DW = $clog2(DWELL) + 1;
    localparam logic [DW-1:0]    DLAST = DW'(DWELL - 1);
    localparam logic [WIDTH-1:0] HI    = WIDTH'(HIGH_MARK);
    localparam logic [WIDTH-1:0] LO    = WIDTH'(LOW_MARK);
    localparam logic [WIDTH-1:0] QMAX  = '1;

    typedef enum logic [1:0] {
        CLEAR,
        RISING,
        CONGESTED,
        FALLING
    } state_t;

    logic             arr_s1, arr_s2, arr_p;
    logic             dep_s1, dep_s2, dep_p;
    logic             arr_evt, dep_evt;
    logic [WIDTH-1:0] qcnt;
    logic             viol;
    logic             cong;
    state_t           state;
    logic [DW-1:0]    dcnt;

    assign arr_evt = arr_s2 & ~arr_p;
    assign dep_evt = dep_s2 & ~dep_p;

    // Two-flop synchronizers plus history flop for edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            arr_s1 <= 1'b0;
            arr_s2 <= 1'b0;
            arr_p  <= 1'b0;
            dep_s1 <= 1'b0;
            dep_s2 <= 1'b0;
            dep_p  <= 1'b0;
        end else begin
            arr_s1 <= bus.car_arrive;
            arr_s2 <= arr_s1;
            arr_p  <= arr_s2;
            dep_s1 <= bus.car_depart;
            dep_s2 <= dep_s1;
            dep_p  <= dep_s2;
        end
    end

    // Saturating up/down queue estimate; coincident events cancel
    always_ff @(posedge clock) begin
        if (reset) begin
            qcnt <= '0;
        end else if (arr_evt && !dep_evt && qcnt != QMAX) begin
            qcnt <= qcnt + 1'b1;
        end else if (dep_evt && !arr_evt && qcnt != '0) begin
            qcnt <= qcnt - 1'b1;
        end
    end

    // One-cycle pulse for a departure made against a plain stop light
    always_ff @(posedge clock) begin
        if (reset) begin
            viol <= 1'b0;
        end else begin
            viol <= dep_evt && (bus.main_road == 2'b10);
        end
    end

    // Hysteresis FSM on the registered count; cong mirrors
    // membership of {CONGESTED, FALLING} without a combinational decode
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            dcnt  <= '0;
            cong  <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (qcnt >= HI) begin
                        state <= RISING;
                        dcnt  <= '0;
                    end
                end
                RISING: begin
                    if (qcnt < HI) begin
                        state <= CLEAR;
                        dcnt  <= '0;
                    end else if (dcnt == DLAST) begin
                        state <= CONGESTED;
                        dcnt  <= '0;
                        cong  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                CONGESTED: begin
                    if (qcnt <= LO) begin
                        state <= FALLING;
                        dcnt  <= '0;
                    end
                end
                FALLING: begin
                    if (qcnt > LO) begin
                        state <= CONGESTED;
                        dcnt  <= '0;
                    end else if (dcnt == DLAST) begin
                        state <= CLEAR;
                        dcnt  <= '0;
                        cong  <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.queue_count = qcnt;
    assign bus.violation   = viol;
    assign bus.congestion  = cong;
endmodule

// File: tb/tb_congestion_detector.sv
// Scoreboard bench: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_congestion_detector;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    congestion_detector_if #(.WIDTH(8)) bus ();

    congestion_detector #(
        .WIDTH(8),
        .HIGH_MARK(10),
        .LOW_MARK(4),
        .DWELL(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int    at;
        int    sig;
        int    val;
        string name;
    } exp_t;

    localparam int SQ = 0;
    localparam int SC = 1;
    localparam int SV = 2;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_at(input int at, input int sig,
                             input int val, input string name);
        sb.push_back('{at, sig, val, name});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: compare every expectation that falls due this cycle
    always @(negedge clock) begin : monitor
        int act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                if (sb[i].sig == SQ)
                    act = int'(bus.queue_count);
                else if (sb[i].sig == SC)
                    act = int'(bus.congestion);
                else
                    act = int'(bus.violation);
                checks++;
                if (sb[i].at != cyc || act != sb[i].val) begin
                    fails++;
                    $display("FAIL %s cycle %0d (due %0d): got %0d, required %0d",
                             sb[i].name, cyc, sb[i].at, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic arrive(input int q);
        int c = cyc;
        expect_at(c + 3, SQ, q, "arrive_q");
        bus.car_arrive = 1'b1;
        tick(2);
        bus.car_arrive = 1'b0;
        tick(2);
    endtask

    task automatic depart(input int q, input logic [1:0] mr, input int v);
        int c = cyc;
        expect_at(c + 2, SV, 0, "viol_before");
        expect_at(c + 3, SQ, q, "depart_q");
        expect_at(c + 3, SV, v, "viol_pulse");
        expect_at(c + 4, SV, 0, "viol_after");
        bus.main_road  = mr;
        bus.car_depart = 1'b1;
        tick(2);
        bus.car_depart = 1'b0;
        tick(2);
        bus.main_road = 2'b00;
    endtask

    task automatic both(input int q);
        int c = cyc;
        expect_at(c + 3, SQ, q, "both_q");
        expect_at(c + 5, SQ, q, "both_q_late");
        bus.car_arrive = 1'b1;
        bus.car_depart = 1'b1;
        tick(2);
        bus.car_arrive = 1'b0;
        bus.car_depart = 1'b0;
        tick(2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : stimulus
        int c;
        reset          = 1'b1;
        bus.car_arrive = 1'b0;
        bus.car_depart = 1'b0;
        bus.main_road  = 2'b00;

        @(negedge clock);
        expect_at(cyc + 1, SQ, 0, "reset_q");
        expect_at(cyc + 1, SC, 0, "reset_cong");
        expect_at(cyc + 1, SV, 0, "reset_viol");
        tick(1);
        reset = 1'b0;
        tick(2);

        // Fill to HIGH_MARK; congestion 4 edges after count hits 10
        for (int i = 1; i <= 10; i++) begin
            c = cyc;
            expect_at(c + 3, SC, 0, "fill_cong");
            arrive(i);
        end
        expect_at(c + 6, SC, 0, "rise_early");
        expect_at(c + 7, SC, 1, "rise_edge");
        tick(4);

        // Drain through hysteresis band down to LOW_MARK
        for (int k = 1; k <= 6; k++) begin
            c = cyc;
            expect_at(c + 3, SC, 1, "drain_cong");
            depart(10 - k, 2'b00, 0);
        end
        expect_at(c + 6, SC, 1, "fall_early");
        expect_at(c + 7, SC, 0, "fall_edge");
        tick(4);

        // Violation only for code 10, all codes still decrement
        depart(3, 2'b10, 1);
        depart(2, 2'b00, 0);
        depart(1, 2'b01, 0);
        depart(0, 2'b11, 0);

        // Underflow guards at zero
        both(0);
        depart(0, 2'b00, 0);
        arrive(1);
        both(1);
        depart(0, 2'b00, 0);

        // Held sensor counts once
        c = cyc;
        expect_at(c + 2, SQ, 0, "hold_pre");
        expect_at(c + 3, SQ, 1, "hold_q");
        expect_at(c + 30, SQ, 1, "hold_mid");
        expect_at(c + 53, SQ, 1, "hold_end");
        bus.car_arrive = 1'b1;
        tick(50);
        bus.car_arrive = 1'b0;
        tick(4);

        // Build to 12 and congested, then reset with arrival held
        for (int i = 2; i <= 12; i++) arrive(i);
        tick(6);
        c = cyc;
        expect_at(c + 1, SQ, 12, "pre_rst_q");
        expect_at(c + 1, SC, 1, "pre_rst_cong");
        tick(2);
        c = cyc;
        expect_at(c + 1, SQ, 0, "rst_q");
        expect_at(c + 1, SC, 0, "rst_cong");
        expect_at(c + 1, SV, 0, "rst_viol");
        expect_at(c + 2, SC, 0, "rst_cong_after");
        expect_at(c + 3, SQ, 0, "rst_q_wait");
        expect_at(c + 4, SQ, 1, "rst_q_count");
        expect_at(c + 8, SQ, 1, "rst_q_once");
        bus.car_arrive = 1'b1;
        reset          = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        bus.car_arrive = 1'b0;
        tick(6);

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
